// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Sole owner of the byte-wide unified RAM/IO port. Arbitrates the port
//   between instruction fetch (IF) and the load/store stage (MEM), breaks
//   each 1/2/4-byte access into single-byte RAM cycles, assembles
//   little-endian read data and returns a one-cycle done pulse to the
//   requester. Also handles IO-write back-pressure, IF flush on redirect
//   and a global freeze (rdy=0).
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   i_rdy              global ready; low freezes the whole block
//   i_if_req           IF fetch request (level, held until o_if_done)
//   i_if_addr          fetch address, always a 4-byte read
//   i_if_flush         abort any IF transaction (control-flow redirect)
//   o_if_done          one-cycle pulse, o_if_inst valid
//   o_if_inst          fetched instruction
//   i_ls_req           MEM request (level, held until o_ls_done)
//   i_ls_we            1 = store, 0 = load
//   i_ls_addr          byte address
//   i_ls_len           byte count 1, 2 or 4
//   i_ls_wdata         store data, low i_ls_len bytes used
//   o_ls_done          one-cycle pulse
//   o_ls_rdata         load data, zero-extended
//   i_ram_din          RAM/IO read byte (registered RAM, 1-cycle latency)
//   o_ram_dout         write byte
//   o_ram_a            byte address
//   o_ram_wr           1 = write, 0 = read
//   i_io_buffer_full   IO write FIFO full
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_HI  = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rdy,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  input  logic              i_if_flush,
  output logic              o_if_done,
  output logic [31:0]       o_if_inst,
  input  logic              i_ls_req,
  input  logic              i_ls_we,
  input  logic [ADDR_W-1:0] i_ls_addr,
  input  logic [2:0]        i_ls_len,
  input  logic [31:0]       i_ls_wdata,
  output logic              o_ls_done,
  output logic [31:0]       o_ls_rdata,
  input  logic [7:0]        i_ram_din,
  output logic [7:0]        o_ram_dout,
  output logic [ADDR_W-1:0] o_ram_a,
  output logic              o_ram_wr,
  input  logic              i_io_buffer_full
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RD     = 2'd1,
    S_WR     = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  // Latched transaction: owner (1 = MEM, 0 = IF), base address, length,
  // store data, byte counter and the partially assembled read word.
  logic              r_owner_ls;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_len;
  logic [31:0]       r_wdata;
  logic [2:0]        r_cnt;
  logic [31:0]       r_buf;

  // Registered outputs.
  logic [ADDR_W-1:0] r_ram_a;
  logic [7:0]        r_ram_dout;
  logic [31:0]       r_if_inst;
  logic [31:0]       r_ls_rdata;

  logic              w_take_ls;
  logic              w_take_if;
  logic [2:0]        w_ls_len;
  logic [2:0]        w_cnt_inc;
  logic [ADDR_W-1:0] w_addr_inc;
  logic              w_io_stall;
  logic              w_flush_rd;
  logic              w_last_wr;
  logic [31:0]       w_rd_word;
  logic [7:0]        w_wr_next_byte;

  // A malformed length of 0 or above 4 would stall the write path forever,
  // so it is folded onto the nearest legal size.
  always_comb begin
    w_ls_len = i_ls_len;
    if (i_ls_len == 3'd0) begin
      w_ls_len = 3'd1;
    end else if (i_ls_len > 3'd4) begin
      w_ls_len = 3'd4;
    end
  end

  // MEM wins over IF in IDLE; a flush in IDLE hides the fetch request for
  // that cycle so a stale fetch address is never accepted.
  assign w_take_ls  = (r_state == S_IDLE) && i_rdy && i_ls_req;
  assign w_take_if  = (r_state == S_IDLE) && i_rdy && !i_ls_req &&
                      i_if_req && !i_if_flush;

  assign w_cnt_inc  = r_cnt + 3'd1;
  assign w_addr_inc = r_addr + ADDR_W'(w_cnt_inc);

  // IO space is decided on the byte currently on the bus, so the held byte
  // is re-issued unchanged until the FIFO has room.
  assign w_io_stall = (r_ram_a[17:16] == IO_HI) && i_io_buffer_full;
  assign w_flush_rd = (r_state == S_RD) && !r_owner_ls && i_if_flush;
  assign w_last_wr  = (w_cnt_inc == r_len);

  // Read word with the byte arriving this cycle merged in. RAM data lags the
  // address by one cycle, so at count c the byte on i_ram_din is byte c-1.
  always_comb begin
    w_rd_word = r_buf;
    for (int k = 0; k < 4; k++) begin
      if (r_cnt == 3'(k + 1)) begin
        w_rd_word[8*k +: 8] = i_ram_din;
      end
    end
  end

  // Store byte to present on the bus once the current byte is accepted.
  always_comb begin
    w_wr_next_byte = r_wdata[7:0];
    for (int k = 1; k < 4; k++) begin
      if (w_cnt_inc == 3'(k)) begin
        w_wr_next_byte = r_wdata[8*k +: 8];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic. With rdy low everything holds, including FINISH, so a
  // done pulse that was frozen re-appears when rdy returns.
  always_comb begin
    w_next = r_state;
    if (i_rdy) begin
      case (r_state)
        S_IDLE: begin
          if (w_take_ls) begin
            w_next = i_ls_we ? S_WR : S_RD;
          end else if (w_take_if) begin
            w_next = S_RD;
          end
        end
        S_RD: begin
          if (w_flush_rd) begin
            w_next = S_IDLE;
          end else if (r_cnt == r_len) begin
            w_next = S_FINISH;
          end
        end
        S_WR: begin
          if (!w_io_stall && w_last_wr) begin
            w_next = S_FINISH;
          end
        end
        S_FINISH: begin
          w_next = S_IDLE;
        end
        default: begin
          w_next = S_IDLE;
        end
      endcase
    end
  end

  // Output logic. Strobes are gated by rdy so nothing is written or
  // acknowledged while the system is frozen.
  always_comb begin
    o_ram_wr  = 1'b0;
    o_if_done = 1'b0;
    o_ls_done = 1'b0;
    if (i_rdy) begin
      case (r_state)
        S_WR: begin
          o_ram_wr = !w_io_stall;
        end
        S_FINISH: begin
          o_ls_done = r_owner_ls;
          o_if_done = !r_owner_ls && !i_if_flush;
        end
        default: begin
        end
      endcase
    end
  end

  // Datapath: latch the request, step the byte counter and address, merge
  // read bytes and publish the finished word to the owner's data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner_ls <= 1'b0;
      r_addr     <= '0;
      r_len      <= 3'd0;
      r_wdata    <= 32'd0;
      r_cnt      <= 3'd0;
      r_buf      <= 32'd0;
      r_ram_a    <= '0;
      r_ram_dout <= 8'd0;
      r_if_inst  <= 32'd0;
      r_ls_rdata <= 32'd0;
    end else if (i_rdy) begin
      case (r_state)
        S_IDLE: begin
          if (w_take_ls || w_take_if) begin
            r_owner_ls <= w_take_ls;
            r_addr     <= w_take_ls ? i_ls_addr : i_if_addr;
            r_len      <= w_take_ls ? w_ls_len : 3'd4;
            r_wdata    <= w_take_ls ? i_ls_wdata : 32'd0;
            r_cnt      <= 3'd0;
            r_buf      <= 32'd0;
            r_ram_a    <= w_take_ls ? i_ls_addr : i_if_addr;
            r_ram_dout <= w_take_ls ? i_ls_wdata[7:0] : 8'd0;
          end
        end
        S_RD: begin
          if (!w_flush_rd) begin
            r_buf <= w_rd_word;
            if (r_cnt == r_len) begin
              if (r_owner_ls) begin
                r_ls_rdata <= w_rd_word;
              end else begin
                r_if_inst <= w_rd_word;
              end
            end else begin
              r_cnt <= w_cnt_inc;
              if (w_cnt_inc < r_len) begin
                r_ram_a <= w_addr_inc;
              end
            end
          end
        end
        S_WR: begin
          if (!w_io_stall && !w_last_wr) begin
            r_cnt      <= w_cnt_inc;
            r_ram_a    <= w_addr_inc;
            r_ram_dout <= w_wr_next_byte;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_ram_a    = r_ram_a;
  assign o_ram_dout = r_ram_dout;
  assign o_if_inst  = r_if_inst;
  assign o_ls_rdata = r_ls_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Purpose:
//   Self-checking bench for mem_arbiter. A byte-addressed RAM model answers
//   the DUT port; a separate reference memory plus latency arithmetic give
//   the expected data and timing of every transaction.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        ifReq;
  logic [31:0] ifAddr;
  logic        ifFlush;
  logic        ifDone;
  logic [31:0] ifInst;
  logic        lsReq;
  logic        lsWe;
  logic [31:0] lsAddr;
  logic [2:0]  lsLen;
  logic [31:0] lsWdata;
  logic        lsDone;
  logic [31:0] lsRdata;
  logic [7:0]  ramDin;
  logic [7:0]  ramDout;
  logic [31:0] ramA;
  logic        ramWr;
  logic        ioFull;

  int total = 0;
  int bad   = 0;

  logic [7:0]  ramMem [logic [31:0]];
  logic [7:0]  refMem [logic [31:0]];
  logic [39:0] wrLog [$];

  mem_arbiter #(.ADDR_W(32), .IO_HI(2'b11)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_rdy            (rdy),
    .i_if_req         (ifReq),
    .i_if_addr        (ifAddr),
    .i_if_flush       (ifFlush),
    .o_if_done        (ifDone),
    .o_if_inst        (ifInst),
    .i_ls_req         (lsReq),
    .i_ls_we          (lsWe),
    .i_ls_addr        (lsAddr),
    .i_ls_len         (lsLen),
    .i_ls_wdata       (lsWdata),
    .o_ls_done        (lsDone),
    .o_ls_rdata       (lsRdata),
    .i_ram_din        (ramDin),
    .o_ram_dout       (ramDout),
    .o_ram_a          (ramA),
    .o_ram_wr         (ramWr),
    .i_io_buffer_full (ioFull)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unwritten locations hold an address-derived pattern so every byte lane
  // carries distinct data.
  function automatic logic [7:0] defPat(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] ramRd(input logic [31:0] a);
    return ramMem.exists(a) ? ramMem[a] : defPat(a);
  endfunction

  function automatic logic [7:0] refRd(input logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : defPat(a);
  endfunction

  // Registered RAM, clock-enabled by rdy like the rest of the system.
  always @(posedge clk) begin
    if (rdy) begin
      ramDin <= ramRd(ramA);
    end
    if (ramWr) begin
      ramMem[ramA] = ramDout;
      wrLog.push_back({ramA, ramDout});
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction from acceptance to the cycle after done. freezeAt>0
  // drops rdy for 4 cycles starting at that offset; ioFullCycles raises
  // io_buffer_full for offsets 1..N and expStall is how many cycles the
  // rules say that costs.
  task automatic applyStimulus(input bit isIf, input bit we,
                               input logic [31:0] addr, input int len,
                               input logic [31:0] wdata, input int freezeAt,
                               input int ioFullCycles, input int expStall,
                               input bit noisyFlush, input string tag);
    logic [31:0] expData;
    int          expLat;
    int          doneCyc;
    int          wrBase;
    bit          seen;
    logic        myDone;
    logic        otherDone;
    expData = 32'd0;
    if (!we) begin
      for (int k = 0; k < len; k++) expData[8*k +: 8] = refRd(addr + 32'(k));
    end
    expLat  = (we ? len + 1 : len + 2) + expStall + ((freezeAt > 0) ? 4 : 0);
    wrBase  = wrLog.size();
    doneCyc = -1;
    seen    = 1'b0;
    if (isIf) begin
      ifReq = 1'b1; ifAddr = addr;
    end else begin
      lsReq = 1'b1; lsWe = we; lsAddr = addr; lsLen = 3'(len); lsWdata = wdata;
    end
    for (int cyc = 0; cyc <= expLat + 8 && !seen; cyc++) begin
      rdy     = !(freezeAt > 0 && cyc >= freezeAt && cyc < freezeAt + 4);
      ioFull  = (cyc >= 1 && cyc <= ioFullCycles);
      ifFlush = noisyFlush ? 1'($urandom_range(1, 0)) : 1'b0;
      #1;
      myDone    = isIf ? ifDone : lsDone;
      otherDone = isIf ? lsDone : ifDone;
      checkOutput({tag, ".otherDone"}, 32'(otherDone), 32'd0);
      if (!we && freezeAt == 0 && cyc >= 1 && cyc <= len) begin
        checkOutput({tag, ".ramA"}, ramA, addr + 32'(cyc - 1));
      end
      if (myDone) begin
        seen = 1'b1; doneCyc = cyc;
      end
      tick();
    end
    ifReq = 1'b0; lsReq = 1'b0; rdy = 1'b1; ioFull = 1'b0; ifFlush = 1'b0;
    #1;
    checkOutput({tag, ".latency"}, 32'(doneCyc), 32'(expLat));
    checkOutput({tag, ".donePulse"}, 32'({ifDone, lsDone}), 32'd0);
    if (we) begin
      checkOutput({tag, ".wrCount"}, 32'(wrLog.size() - wrBase), 32'(len));
      for (int k = 0; k < len && wrBase + k < wrLog.size(); k++) begin
        checkOutput({tag, ".wrAddr"}, wrLog[wrBase + k][39:8], addr + 32'(k));
        checkOutput({tag, ".wrData"}, 32'(wrLog[wrBase + k][7:0]),
                    32'(wdata[8*k +: 8]));
      end
      for (int k = 0; k < len; k++) refMem[addr + 32'(k)] = wdata[8*k +: 8];
    end else begin
      checkOutput({tag, ".noWrite"}, 32'(wrLog.size() - wrBase), 32'd0);
      checkOutput({tag, ".data"}, isIf ? ifInst : lsRdata, expData);
    end
    tick();
  endtask

  initial begin
    int lsAt, ifAt, lsCnt, ifCnt;
    logic [31:0] expInst;
    rst = 1'b1; rdy = 1'b1; ifReq = 1'b0; ifAddr = 32'd0; ifFlush = 1'b0;
    lsReq = 1'b0; lsWe = 1'b0; lsAddr = 32'd0; lsLen = 3'd1; lsWdata = 32'd0;
    ioFull = 1'b0; ramDin = 8'd0;
    ramMem[32'h100] = 8'h13; ramMem[32'h101] = 8'h05;
    ramMem[32'h102] = 8'h10; ramMem[32'h103] = 8'h00;
    refMem[32'h100] = 8'h13; refMem[32'h101] = 8'h05;
    refMem[32'h102] = 8'h10; refMem[32'h103] = 8'h00;
    $display("[TB] start");

    tick(); tick();
    checkOutput("rst.outs", {ramA[7:0], ramDout, 8'(ramWr), 8'({ifDone, lsDone})}, 32'd0);
    checkOutput("rst.data", ifInst | lsRdata, 32'd0);
    rst = 1'b0;
    tick();

    // Fetch of the known instruction.
    applyStimulus(1, 0, 32'h100, 4, 32'd0, 0, 0, 0, 0, "fetch");
    checkOutput("fetch.inst", ifInst, 32'h0010_0513);

    // Store halfword, then load one of its bytes back.
    applyStimulus(0, 1, 32'h200, 2, 32'hAABB_CCDD, 0, 0, 0, 0, "sh");
    applyStimulus(0, 0, 32'h201, 1, 32'd0, 0, 0, 0, 0, "lb");
    checkOutput("lb.const", lsRdata, 32'h0000_00CC);

    // Contention: MEM first, IF on the following IDLE cycle.
    lsAt = -1; ifAt = -1; lsCnt = 0; ifCnt = 0;
    lsReq = 1'b1; lsWe = 1'b0; lsAddr = 32'h201; lsLen = 3'd1;
    ifReq = 1'b1; ifAddr = 32'h100;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (lsDone) begin lsCnt++; lsAt = c; end
      if (ifDone) begin ifCnt++; ifAt = c; end
      tick();
      if (lsAt >= 0) lsReq = 1'b0;
      if (ifAt >= 0) ifReq = 1'b0;
    end
    checkOutput("cont.lsAt", 32'(lsAt), 32'd3);
    checkOutput("cont.ifAt", 32'(ifAt), 32'd10);
    checkOutput("cont.counts", 32'({lsCnt[7:0], ifCnt[7:0]}), 32'h0101);
    checkOutput("cont.lsData", lsRdata, 32'h0000_00CC);
    checkOutput("cont.ifData", ifInst, 32'h0010_0513);

    // IO store held off by a full FIFO for three cycles.
    applyStimulus(0, 1, 32'h0003_0000, 1, 32'h41, 0, 3, 3, 0, "io");

    // Flush at cnt=2 of a fetch, redirected fetch from 0x400.
    ifAt = -1; ifCnt = 0;
    expInst = {refRd(32'h403), refRd(32'h402), refRd(32'h401), refRd(32'h400)};
    ifReq = 1'b1; ifAddr = 32'h100;
    for (int c = 0; c < 16; c++) begin
      ifFlush = (c == 3);
      if (c == 3) ifAddr = 32'h400;
      #1;
      if (ifDone) begin ifCnt++; ifAt = c; end
      tick();
      if (ifAt >= 0) ifReq = 1'b0;
    end
    ifFlush = 1'b0;
    checkOutput("flush.count", 32'(ifCnt), 32'd1);
    checkOutput("flush.at", 32'(ifAt), 32'd10);
    checkOutput("flush.inst", ifInst, expInst);

    // Freeze for 4 cycles in the middle of a load.
    applyStimulus(0, 0, 32'h100, 4, 32'd0, 2, 0, 0, 0, "freeze");

    // Reset in the middle of a store.
    lsCnt = 0;
    lsReq = 1'b1; lsWe = 1'b1; lsAddr = 32'h5000; lsLen = 3'd4;
    lsWdata = 32'h1234_5678;
    for (int c = 0; c < 10; c++) begin
      rst = (c == 2);
      if (c >= 3) lsReq = 1'b0;
      #1;
      if (lsDone) lsCnt++;
      if (c == 3) begin
        checkOutput("rstMid.bus", {ramA[15:0], ramDout, 8'(ramWr)}, 32'd0);
        checkOutput("rstMid.data", {ifInst | lsRdata}, 32'd0);
      end
      tick();
    end
    checkOutput("rstMid.noDone", 32'(lsCnt), 32'd0);

    // Randomised mix of fetches, loads and stores.
    for (int n = 0; n < 40; n++) begin
      int sel, len, frz, ioc, stall, base;
      bit isIf, we;
      logic [31:0] addr;
      sel  = int'($urandom_range(7, 0));
      isIf = ($urandom_range(3, 0) == 0);
      we   = isIf ? 1'b0 : 1'($urandom_range(1, 0));
      len  = isIf ? 4 : (1 << $urandom_range(2, 0));
      ioc  = 0; stall = 0;
      if (sel <= 4) begin
        addr = {16'h0000, 16'($urandom_range(16'hFFF0, 16'h0600))};
        ioc  = int'($urandom_range(2, 0));
      end else if (sel <= 6) begin
        addr  = 32'h0003_0000 + 32'($urandom_range(255, 0));
        ioc   = int'($urandom_range(3, 0));
        stall = we ? ioc : 0;
      end else begin
        addr = 32'hFFFF_FFFD + 32'($urandom_range(1, 0));
      end
      base = (we ? len + 1 : len + 2) + stall;
      frz  = (ioc == 0 && $urandom_range(3, 0) == 0) ?
             int'($urandom_range(base, 1)) : 0;
      applyStimulus(isIf, we, addr, len, $urandom, frz, ioc, stall,
                    !isIf && ($urandom_range(1, 0) == 1), "rand");
      for (int g = int'($urandom_range(2, 0)); g > 0; g--) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
